// File: rtl/goal_scoreboard_pkg.sv
// goal_scoreboard_pkg: shared FSM states, winner codes and BCD helpers
package goal_scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GOAL_HOLD = 2'd2,
    OVER      = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // Packed BCD orders the same way as binary, so a plain compare picks the leader.
  function automatic logic [1:0] decide_winner(input logic [7:0] s1, input logic [7:0] s2);
    return s1 > s2 ? WIN_T1 : s2 > s1 ? WIN_T2 : WIN_DRAW;
  endfunction

  // Two-digit BCD increment; callers guard against BCD_MAX.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/goal_scoreboard_if.sv
// goal_scoreboard_if: game-controller inputs and display/respawn outputs of the scoreboard
interface goal_scoreboard_if;
  logic        game_on;
  logic        game_over;
  logic [18:0] ball_hor_position;
  logic [18:0] ball_ver_position;
  logic [7:0]  team1_score;
  logic [7:0]  team2_score;
  logic        goal_pulse;
  logic        scoring_team;
  logic        ball_respawn;
  logic [1:0]  winner;

  modport master (
    output game_on, game_over, ball_hor_position, ball_ver_position,
    input  team1_score, team2_score, goal_pulse, scoring_team, ball_respawn, winner
  );

  modport slave (
    input  game_on, game_over, ball_hor_position, ball_ver_position,
    output team1_score, team2_score, goal_pulse, scoring_team, ball_respawn, winner
  );
endinterface

// File: rtl/goal_scoreboard_bcd_counter_2d.sv
// bcd_counter_2d: saturating two-digit BCD counter (00..99) with increment enable
module bcd_counter_2d
  import goal_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value
);

  // Advance one count per enabled cycle, sticking at 99.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= 8'h00;
    else if (inc && value != BCD_MAX) value <= bcd_inc(value);

endmodule

// File: rtl/goal_scoreboard.sv
// goal_scoreboard: goal detection, BCD scores, respawn hold sequencing and winner decision
module goal_scoreboard
  import goal_scoreboard_pkg::*;
#(
  parameter int unsigned FIELD_LEFT    = 0,
  parameter int unsigned FIELD_RIGHT   = 639,
  parameter int unsigned GOAL_CENTER_Y = 240,
  parameter int unsigned GOAL_RADIUS   = 60,
  parameter int unsigned BALL_RADIUS   = 8,
  parameter int unsigned HOLD_CYCLES   = 50000000
)(
  input  logic              clk,
  input  logic              rst_n,
  goal_scoreboard_if.slave  bus
);

  localparam int          CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [19:0] LEFT_LIM = 20'(FIELD_LEFT + BALL_RADIUS);
  localparam logic [19:0] RIGHT_LIM = 20'(FIELD_RIGHT - BALL_RADIUS);
  localparam logic [19:0] CY       = 20'(GOAL_CENTER_Y);
  localparam logic [19:0] RAD      = 20'(GOAL_RADIUS);
  localparam logic [CW-1:0] TERM   = CW'(HOLD_CYCLES - 1);

  state_t      state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic        on_r, over_r;
  logic [18:0] hor_r, ver_r;
  logic [19:0] hor, ver, dy;
  logic        in_window, left_hit, right_hit, goal_any;
  logic        inc1, inc2, pulse, pulse_next, team, team_next;
  logic [7:0]  score1, score2;

  assign hor       = {1'b0, hor_r};
  assign ver       = {1'b0, ver_r};
  assign dy        = ver >= CY ? ver - CY : CY - ver;
  assign in_window = dy <= RAD;
  assign left_hit  = hor <= LEFT_LIM && in_window;
  assign right_hit = hor >= RIGHT_LIM && in_window;
  assign goal_any  = left_hit | right_hit;

  // Register the controller inputs once; all decisions use these copies.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      on_r   <= 1'b0;
      over_r <= 1'b0;
      hor_r  <= '0;
      ver_r  <= '0;
    end else begin
      on_r   <= bus.game_on;
      over_r <= bus.game_over;
      hor_r  <= bus.ball_hor_position;
      ver_r  <= bus.ball_ver_position;
    end

  // State, hold counter, goal strobe and last scorer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      team  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      team  <= team_next;
    end

  // Next state: game over beats a same-cycle goal; right goal wins a double hit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    inc1       = 1'b0;
    inc2       = 1'b0;
    pulse_next = 1'b0;
    team_next  = team;
    case (state)
      IDLE:
        state_next = over_r ? OVER : on_r ? PLAY : IDLE;
      PLAY:
        if (over_r) state_next = OVER;
        else if (goal_any) begin
          inc1       = right_hit;
          inc2       = ~right_hit;
          pulse_next = 1'b1;
          team_next  = ~right_hit;
          cnt_next   = '0;
          state_next = GOAL_HOLD;
        end
      GOAL_HOLD:
        if (over_r) begin
          state_next = OVER;
          cnt_next   = '0;
        end else if (cnt == TERM) begin
          state_next = goal_any ? GOAL_HOLD : PLAY;
          cnt_next   = goal_any ? TERM : '0;
        end else cnt_next = cnt + CW'(1);
      OVER:
        state_next = OVER;
    endcase
  end

  bcd_counter_2d u_team1 (.clk(clk), .rst_n(rst_n), .inc(inc1), .value(score1));
  bcd_counter_2d u_team2 (.clk(clk), .rst_n(rst_n), .inc(inc2), .value(score2));

  assign bus.team1_score  = score1;
  assign bus.team2_score  = score2;
  assign bus.goal_pulse   = pulse;
  assign bus.scoring_team = team;
  assign bus.ball_respawn = state == GOAL_HOLD;
  assign bus.winner       = state == OVER ? decide_winner(score1, score2) : WIN_NONE;

endmodule

// File: tb/tb_goal_scoreboard.sv
// tb_goal_scoreboard: directed and randomized checks against an integer score model
module tb_goal_scoreboard;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0, fails = 0, pulses = 0, t1 = 0, t2 = 0;

  always #5 clk = ~clk;

  goal_scoreboard_if bus();
  goal_scoreboard #(.HOLD_CYCLES(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.goal_pulse) pulses++;
  endtask

  task automatic place(input int x, input int y);
    bus.ball_hor_position = 19'(x);
    bus.ball_ver_position = 19'(y);
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_t1"}, 32'(bus.team1_score), 32'(bcd(t1)));
    check({tag, "_t2"}, 32'(bus.team2_score), 32'(bcd(t2)));
  endtask

  task automatic do_reset(input logic on);
    rst_n = 1'b0;
    place(320, 240);
    bus.game_on = on;
    bus.game_over = 1'b0;
    t1 = 0;
    t2 = 0;
    #2;
    check_scores("rst");
    check("rst_pulse", 32'(bus.goal_pulse), 0);
    check("rst_team", 32'(bus.scoring_team), 0);
    check("rst_respawn", 32'(bus.ball_respawn), 0);
    check("rst_winner", 32'(bus.winner), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic try_ball(input int x, input int y, input bit finish = 1'b1);
    int  dy = y >= 240 ? y - 240 : 240 - y;
    bit  l = x <= 8 && dy <= 60;
    bit  r = x >= 631 && dy <= 60;
    int  p = pulses;
    int  hi = 1;
    place(x, y);
    tick();
    check("pulse_early", 32'(bus.goal_pulse), 0);
    tick();
    if (l || r) begin
      check("pulse", 32'(bus.goal_pulse), 1);
      check("scorer", 32'(bus.scoring_team), r ? 0 : 1);
      if (r) t1 = t1 < 99 ? t1 + 1 : 99;
      else   t2 = t2 < 99 ? t2 + 1 : 99;
      check_scores("goal");
      check("respawn_on", 32'(bus.ball_respawn), 1);
      if (finish) begin
        place(320, 240);
        for (int i = 0; i < 40 && bus.ball_respawn; i++) begin
          tick();
          if (bus.ball_respawn) hi++;
        end
        check("hold_len", 32'(hi), HOLD);
        check("one_pulse", 32'(pulses - p), 1);
      end
    end else begin
      repeat (2) tick();
      check("no_goal", 32'(pulses - p), 0);
      check_scores("miss");
      check("miss_respawn", 32'(bus.ball_respawn), 0);
    end
  endtask

  initial begin
    int p, x, y;
    bus.game_on = 1'b0;
    bus.game_over = 1'b0;
    place(320, 240);
    #1;
    do_reset(1'b1);

    p = pulses;
    place(300, 240);
    repeat (100) tick();
    check("idle_play_pulses", 32'(pulses - p), 0);
    check_scores("idle_play");
    check("play_winner", 32'(bus.winner), 0);

    try_ball(5, 240);
    try_ball(635, 350);
    try_ball(635, 300);

    // edge and window boundaries
    try_ball(8, 240);
    try_ball(9, 240);
    try_ball(631, 180);
    try_ball(630, 240);
    try_ball(0, 179);
    try_ball(639, 301);
    try_ball(0, 0);
    try_ball(2, 300);

    // ball parked in the goal: hold must not rearm
    p = pulses;
    try_ball(2, 200, 1'b0);
    repeat (40) tick();
    check("stay_respawn", 32'(bus.ball_respawn), 1);
    check("stay_pulses", 32'(pulses - p), 1);
    check_scores("stay");
    place(320, 240);
    repeat (3) tick();
    check("stay_release", 32'(bus.ball_respawn), 0);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0: x = $urandom_range(0, 16);
        1: x = $urandom_range(623, 639);
        default: x = $urandom_range(0, 639);
      endcase
      y = $urandom_range(0, 479);
      try_ball(x, y);
    end

    while (t1 < 99) try_ball(635, 240);
    try_ball(635, 240);
    check("sat_t1", 32'(bus.team1_score), 32'h99);

    // reset in the middle of a hold at 03/01
    do_reset(1'b1);
    repeat (3) try_ball(639, 240);
    try_ball(0, 240, 1'b0);
    repeat (5) tick();
    check("midhold_respawn", 32'(bus.ball_respawn), 1);
    check_scores("midhold");
    do_reset(1'b1);
    try_ball(635, 240);

    // game over on the same cycle as a goal at 02/02
    do_reset(1'b1);
    try_ball(635, 240);
    try_ball(635, 240);
    try_ball(5, 240);
    try_ball(5, 240);
    p = pulses;
    place(5, 240);
    bus.game_over = 1'b1;
    repeat (4) tick();
    check("over_pulses", 32'(pulses - p), 0);
    check_scores("over");
    check("over_winner", 32'(bus.winner), 3);
    check("over_respawn", 32'(bus.ball_respawn), 0);
    place(635, 240);
    repeat (4) tick();
    check("over_locked", 32'(pulses - p), 0);
    check_scores("over_locked");

    // game over straight from idle
    do_reset(1'b0);
    bus.game_over = 1'b1;
    repeat (3) tick();
    check("idle_over_winner", 32'(bus.winner), 3);

    do_reset(1'b1);
    try_ball(635, 240);
    bus.game_over = 1'b1;
    repeat (3) tick();
    check("t1_wins", 32'(bus.winner), 1);

    do_reset(1'b1);
    try_ball(5, 240);
    try_ball(635, 240);
    try_ball(5, 240);
    bus.game_over = 1'b1;
    repeat (3) tick();
    check("t2_wins", 32'(bus.winner), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/goal_scoreboard.md
Name: goal_scoreboard

Overview:
- Sits directly downstream of the game controller and consumes its ball position and game_on/game_over flags.
- Detects goals at the left and right field edges and keeps per-team BCD scores (00-99).
- Sequences a goal hold/respawn request and declares the winner at game over.
- Outputs drive the seven-segment score display and the ball respawn logic.

Parameters:
- FIELD_LEFT, 0, x coordinate of the left field edge (pixels)
- FIELD_RIGHT, 639, x coordinate of the right field edge
- GOAL_CENTER_Y, 240, vertical centre of both goal mouths
- GOAL_RADIUS, 60, half-height of each goal mouth
- BALL_RADIUS, 8, ball radius used for edge contact
- HOLD_CYCLES, 50000000, cycles spent in GOAL_HOLD (1 s at 50 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_on  in  1  match running (level)
- game_over  in  1  timer expired (level, sticky)
- ball_hor_position  in  19  ball centre x
- ball_ver_position  in  19  ball centre y
- team1_score  out  8  two BCD digits {tens, ones}
- team2_score  out  8  two BCD digits {tens, ones}
- goal_pulse  out  1  one-cycle strobe per counted goal
- scoring_team  out  1  0 = team1, 1 = team2; valid with goal_pulse, held until next goal
- ball_respawn  out  1  high for the whole GOAL_HOLD state
- winner  out  2  00 none/in play, 01 team1, 10 team2, 11 draw

Behaviour:
- Reset (async, rst_n=0): both scores 8'h00, goal_pulse 0, scoring_team 0, ball_respawn 0, winner 00, state IDLE, hold counter 0.
- Inputs are registered once. Goal detection uses the registered values, so goal_pulse is asserted 2 cycles after the position sample that satisfies the goal condition.
- Left goal (team2 scores): hor <= FIELD_LEFT+BALL_RADIUS and |ver-GOAL_CENTER_Y| <= GOAL_RADIUS.
- Right goal (team1 scores): hor >= FIELD_RIGHT-BALL_RADIUS and the same vertical window.
- Compare in 20-bit unsigned arithmetic, computing the absolute difference without wrap.
- FSM states: IDLE, PLAY, GOAL_HOLD, OVER.
  - IDLE: waits for game_on=1, then goes to PLAY. Scores are not cleared here; only reset clears them.
  - PLAY, goal condition true: increment the scoring team's BCD score, pulse goal_pulse, set scoring_team, go to GOAL_HOLD.
  - GOAL_HOLD: ball_respawn=1; the hold counter counts 0..HOLD_CYCLES-1. At terminal count:
    - ball still inside either goal zone: stay in GOAL_HOLD and keep counting from terminal; no rearm.
    - ball outside both zones: go to PLAY.
  - Any state except IDLE, game_over=1: go to OVER. OVER has priority over a same-cycle goal; that goal is not counted. In IDLE, game_over=1 also goes to OVER.
  - OVER: winner is set from the final scores (01/10/11), ball_respawn=0. OVER is terminal until reset.
- Both goal conditions true in the same cycle (degenerate field): team1 is credited.
- BCD increment:
  - ones 9 goes to 0 with tens+1.
  - The score saturates at 8'h99; a further goal still pulses goal_pulse but the score stays at 99.
- Reset mid-GOAL_HOLD: everything returns to reset values immediately; the counter is cleared.

Decomposition:
- Shared package: FSM state encoding, winner codes (WIN_NONE/WIN_T1/WIN_T2/WIN_DRAW), and the BCD max constant 8'h99.
- One natural sub-module: bcd_counter_2d. It is a saturating two-digit BCD incrementer with async active-low reset and an inc enable, instantiated once per team.

Test Plan:
- Reset then game_on=1; ball at (300,240) for 100 cycles -> scores 00/00, goal_pulse never high, winner 00.
- Ball at (5,240) in PLAY -> goal_pulse 1 cycle, scoring_team=1, team2_score 8'h01, ball_respawn high HOLD_CYCLES cycles (HOLD_CYCLES=16 in bench). Ball moved to (320,240) -> back to PLAY.
- Ball at (635,350) (outside the window, |110|>60) -> no goal. Then (635,300) -> team1_score 8'h01.
- Force team1 to 8'h09, score -> 8'h10. Force 8'h99, score -> stays 8'h99 with goal_pulse.
- Goal condition and game_over in the same cycle with scores 02/02 -> no increment, state OVER, winner 11. Then ball into a goal -> no change.
- rst_n low mid-GOAL_HOLD at scores 03/01 -> immediately 00/00, ball_respawn 0, winner 00.
